// File: rtl/mio_pkg.sv
// Shared definitions for the memory/IO bus controller.
// Holds the address map, the controller FSM state type, the region-decode type
// and the address decoder used by mio_bus.
package mio_pkg;

  localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] RAM_LIMIT  = 32'h0000_0FFF;
  localparam logic [31:0] GPIO_ADDR  = 32'hF000_0000;
  localparam logic [31:0] TIMER_ADDR = 32'hF000_0004;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    R_RAM,
    R_GPIO,
    R_TIMER,
    R_NONE
  } region_e;

  // Word-aligned decode: the byte offset addr[1:0] never affects the region.
  function automatic region_e decode_region(input logic [31:0] addr);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    // Offset form keeps the range check valid for any RAM_BASE.
    if ((waddr - RAM_BASE) <= (RAM_LIMIT - RAM_BASE)) begin
      return R_RAM;
    end else if (waddr == GPIO_ADDR) begin
      return R_GPIO;
    end else if (waddr == TIMER_ADDR) begin
      return R_TIMER;
    end else begin
      return R_NONE;
    end
  endfunction

endpackage

// File: rtl/mio_bus_if.sv
// CPU-side memory port of the memory/IO bus controller.
// master: the CPU (drives request strobe, direction, address, store data).
// slave : mio_bus (returns load data and the ready handshake).
interface mio_bus_if;

  logic        cpu_mio;    // request strobe
  logic        mem_rw;     // 1 = write, 0 = read
  logic [31:0] addr_in;    // byte address
  logic [31:0] wdata_in;   // store data
  logic [31:0] rdata_out;  // load data
  logic        mio_ready;  // access complete

  modport master (
    output cpu_mio,
    output mem_rw,
    output addr_in,
    output wdata_in,
    input  rdata_out,
    input  mio_ready
  );

  modport slave (
    input  cpu_mio,
    input  mem_rw,
    input  addr_in,
    input  wdata_in,
    output rdata_out,
    output mio_ready
  );

endinterface

// File: rtl/mio_timer.sv
// Free-running 32-bit timer with synchronous load.
// Ports:
//   clk - clock
//   rst - synchronous active-low reset, clears the count
//   ld  - load din this edge instead of incrementing
//   din - load value
//   q   - current count (wraps 0xFFFF_FFFF -> 0)
module mio_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic [31:0] din,
  output logic [31:0] q
);

  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (ld) begin
      cnt_q <= din;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/mio_bus.sv
// Memory/IO bus controller behind a single-cycle CPU's memory port.
// Decodes each word access into data RAM, a GPIO register or the timer, and
// holds the CPU (mio_ready low) while a synchronous-read RAM access is in flight.
// Ports:
//   clk, rst   - clock and synchronous active-low reset
//   bus        - CPU request/response (mio_bus_if.slave)
//   ram_addr   - RAM word address (addr_in[RAM_AWIDTH+1:2])
//   ram_we     - RAM write enable, one cycle per accepted RAM write
//   ram_din    - RAM write data
//   ram_dout   - RAM read data, valid RAM_WAIT cycles after the address
//   sw_in      - switch inputs, read at GPIO_ADDR
//   led_out    - LED register, written at GPIO_ADDR
//   timer_out  - current timer value
module mio_bus
  import mio_pkg::*;
#(
  parameter int unsigned RAM_WAIT   = 1,   // RAM read latency, 1..7
  parameter int unsigned RAM_AWIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  mio_bus_if.slave              bus,
  output logic [RAM_AWIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout,
  input  logic [15:0]           sw_in,
  output logic [15:0]           led_out,
  output logic [31:0]           timer_out
);

  localparam logic [2:0] WcntInit = 3'(RAM_WAIT - 1);

  state_e      state_q;
  logic [2:0]  wcnt_q;
  logic [31:0] rdata_q;
  logic [15:0] led_q;

  region_e     region;
  logic        accept;
  logic        acc_wr;
  logic        timer_ld;
  logic [31:0] timer_q;
  logic [31:0] io_rdata;

  assign region = decode_region(bus.addr_in);
  assign accept = (state_q == IDLE) && bus.cpu_mio;
  assign acc_wr = accept && bus.mem_rw;

  // RAM address and data follow the CPU combinationally in every state.
  assign ram_addr = bus.addr_in[RAM_AWIDTH+1:2];
  assign ram_din  = bus.wdata_in;
  // Gated by rst so a request held across reset never writes RAM.
  assign ram_we   = rst && acc_wr && (region == R_RAM);

  assign timer_ld = acc_wr && (region == R_TIMER);

  mio_timer u_timer (
    .clk (clk),
    .rst (rst),
    .ld  (timer_ld),
    .din (bus.wdata_in),
    .q   (timer_q)
  );

  // Single-cycle read data for non-RAM regions; unmapped reads return 0.
  always_comb begin
    io_rdata = '0;
    unique case (region)
      R_GPIO:  io_rdata = {16'h0000, sw_in};
      R_TIMER: io_rdata = timer_q;  // value before this edge's increment
      default: io_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      rdata_q <= '0;
      led_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.cpu_mio) begin
            if ((region == R_RAM) && !bus.mem_rw) begin
              state_q <= WAIT;
              wcnt_q  <= WcntInit;
            end else begin
              state_q <= RESP;
              if (bus.mem_rw) begin
                if (region == R_GPIO) begin
                  led_q <= bus.wdata_in[15:0];
                end
              end else begin
                rdata_q <= io_rdata;
              end
            end
          end
        end
        // Runs to completion even if cpu_mio drops meanwhile.
        WAIT: begin
          if (wcnt_q == 3'd0) begin
            rdata_q <= ram_dout;
            state_q <= RESP;
          end else begin
            wcnt_q <= wcnt_q - 3'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Idle cycles without a request report ready so non-memory instructions never stall.
  assign bus.mio_ready = (state_q == RESP) || ((state_q == IDLE) && !bus.cpu_mio);
  assign bus.rdata_out = rdata_q;
  assign led_out       = led_q;
  assign timer_out     = timer_q;

endmodule

// File: tb/tb_mio_bus.sv
// Directed bench for mio_bus with a behavioural synchronous-read RAM and a
// scoreboard of expected read data and ready latency per access.
module tb_mio_bus;
  import mio_pkg::*;

  localparam int unsigned RamWait = 2;
  localparam int unsigned RamAw   = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [RamAw-1:0] ram_addr;
  logic             ram_we;
  logic [31:0]      ram_din;
  logic [31:0]      ram_dout;
  logic [15:0]      sw_in;
  logic [15:0]      led_out;
  logic [31:0]      timer_out;

  mio_bus_if bus_if ();

  mio_bus #(
    .RAM_WAIT   (RamWait),
    .RAM_AWIDTH (RamAw)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .timer_out (timer_out)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data for the address seen at edge N is on ram_dout
  // after edge N+RamWait-1, i.e. sampled by the DUT at edge N+RamWait.
  logic [31:0] mem     [1<<RamAw];
  logic [31:0] rd_pipe [RamWait];
  int          we_pulses = 0;
  logic [RamAw-1:0] we_addr = '0;
  logic [31:0]      we_data = '0;

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      we_pulses     <= we_pulses + 1;
      we_addr       <= ram_addr;
      we_data       <= ram_din;
    end
    rd_pipe[0] <= mem[ram_addr];
    for (int i = 1; i < RamWait; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_dout = rd_pipe[RamWait-1];

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_rd  = '0;  // rdata_out holds this between reads
  int          pulses0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one access at the current negedge and waits (bounded) for mio_ready.
  // lat_exp counts negedges from presentation to the ready sample.
  task automatic access(input string tag, input logic rw, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rd_exp,
                        input int lat_exp);
    exp_t e;
    int   lat;
    e.tag   = tag;
    e.rdata = rw ? last_rd : rd_exp;
    e.lat   = lat_exp;
    if (!rw) last_rd = rd_exp;
    sb.push_back(e);
    bus_if.cpu_mio  = 1'b1;
    bus_if.mem_rw   = rw;
    bus_if.addr_in  = addr;
    bus_if.wdata_in = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus_if.mio_ready && lat < 20);
    e = sb.pop_front();
    check({e.tag, "_lat"}, 32'(lat), 32'(e.lat));
    check({e.tag, "_rdata"}, bus_if.rdata_out, e.rdata);
    bus_if.cpu_mio = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << RamAw); i++) mem[i] = 32'h0;
    for (int i = 0; i < int'(RamWait); i++) rd_pipe[i] = 32'h0;
    sw_in = 16'h0000;
    // A RAM write held during reset must not reach the RAM.
    bus_if.cpu_mio  = 1'b1;
    bus_if.mem_rw   = 1'b1;
    bus_if.addr_in  = 32'h0000_0010;
    bus_if.wdata_in = 32'h5555_5555;
    @(negedge clk);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    @(negedge clk);
    bus_if.cpu_mio = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rst_rdata", bus_if.rdata_out, 32'h0);
    check("rst_led", 32'(led_out), 32'h0);
    check("rst_timer", timer_out, 32'h0);
    check("rst_ready", 32'(bus_if.mio_ready), 32'h1);
    check("rst_we_pulses", 32'(we_pulses), 32'h0);

    // RAM round trip
    access("ram_wr", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1);
    check("ram_wr_pulses", 32'(we_pulses), 32'h1);
    check("ram_wr_addr", 32'(we_addr), 32'h4);
    check("ram_wr_data", we_data, 32'hDEAD_BEEF);
    check("ram_we_resp", 32'(ram_we), 32'h0);
    @(negedge clk);
    access("ram_rd", 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, RamWait + 1);
    @(negedge clk);
    access("ram_wr_top", 1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 32'h0, 1);
    check("ram_top_addr", 32'(we_addr), 32'h3FF);
    @(negedge clk);
    access("ram_rd_top", 1'b0, 32'h0000_0FFF, 32'h0, 32'h0BAD_F00D, RamWait + 1);
    @(negedge clk);
    access("ram_rd_lowbits", 1'b0, 32'h0000_0013, 32'h0, 32'hDEAD_BEEF, RamWait + 1);
    @(negedge clk);
    // Just past RAM: discarded, no RAM write pulse.
    pulses0 = we_pulses;
    access("past_ram_wr", 1'b1, 32'h0000_1000, 32'h1111_1111, 32'h0, 1);
    check("past_ram_pulses", 32'(we_pulses), 32'(pulses0));
    @(negedge clk);
    access("past_ram_rd", 1'b0, 32'h0000_1000, 32'h0, 32'h0, 1);
    @(negedge clk);

    // GPIO
    access("gpio_wr", 1'b1, 32'hF000_0000, 32'h1234_A5A5, 32'h0, 1);
    check("gpio_led", 32'(led_out), 32'h0000_A5A5);
    @(negedge clk);
    sw_in = 16'h0F0F;
    access("gpio_rd", 1'b0, 32'hF000_0002, 32'h0, 32'h0000_0F0F, 1);
    @(negedge clk);

    // Unmapped
    access("unmap_wr", 1'b1, 32'hF000_0008, 32'hFFFF_0000, 32'h0, 1);
    check("unmap_led", 32'(led_out), 32'h0000_A5A5);
    @(negedge clk);
    access("unmap_rd", 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1);
    @(negedge clk);

    // Timer load and wrap
    access("tmr_wr", 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 32'h0, 1);
    check("tmr_seq0", timer_out, 32'hFFFF_FFFE);
    @(negedge clk);
    check("tmr_seq1", timer_out, 32'hFFFF_FFFF);
    @(negedge clk);
    check("tmr_seq2", timer_out, 32'h0000_0000);
    // Read presented in RESP right after a load: ignored there, accepted in the
    // next IDLE cycle, returning the load value plus the one intervening increment.
    access("tmr_wr2", 1'b1, 32'hF000_0004, 32'hFFFF_FFFD, 32'h0, 1);
    access("tmr_rd_b2b", 1'b0, 32'hF000_0004, 32'h0, 32'hFFFF_FFFE, 2);
    @(negedge clk);

    // Reset during WAIT abandons the read.
    bus_if.cpu_mio = 1'b1;
    bus_if.mem_rw  = 1'b0;
    bus_if.addr_in = 32'h0000_0010;
    @(negedge clk);
    check("abort_in_wait", 32'(dut.state_q), 32'(WAIT));
    rst = 1'b0;
    @(negedge clk);
    check("abort_state", 32'(dut.state_q), 32'(IDLE));
    check("abort_ready0", 32'(bus_if.mio_ready), 32'h0);
    check("abort_rdata", bus_if.rdata_out, 32'h0);
    @(negedge clk);
    check("abort_ready1", 32'(bus_if.mio_ready), 32'h0);
    bus_if.cpu_mio = 1'b0;
    rst = 1'b1;
    last_rd = 32'h0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus_if.mio_ready), 32'h1);
    check("post_rst_led", 32'(led_out), 32'h0);
    access("post_rst_rd", 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, RamWait + 1);
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
